// File: rtl/luma_downsample_writer.sv
// Camera-domain write stage: decimates the luminance stream by 1x/2x/4x (skip or
// box-average) and emits registered frame-buffer writes two cycles after each pixel.
module luma_downsample_writer #(
  parameter int HCOUNT_WIDTH    = 10,
  parameter int VCOUNT_WIDTH    = 9,
  parameter int DATA_WIDTH      = 8,
  parameter int IN_W            = 640,
  parameter int IN_H            = 360,
  parameter int MAX_FACTOR_LOG2 = 2,
  parameter int MEM_WIDTH       = 16,
  parameter int ADDR_WIDTH      = $clog2(IN_W*IN_H)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [1:0]              factor_log2_in,
  input  logic                    mode_in,
  input  logic                    pixel_valid_in,
  input  logic [HCOUNT_WIDTH-1:0] pixel_hcount_in,
  input  logic [VCOUNT_WIDTH-1:0] pixel_vcount_in,
  input  logic [DATA_WIDTH-1:0]   pixel_data_in,
  output logic                    wr_valid_out,
  output logic [ADDR_WIDTH-1:0]   wr_addr_out,
  output logic [MEM_WIDTH-1:0]    wr_data_out,
  output logic                    frame_done_out
);
  localparam int ACC_W  = DATA_WIDTH + 2*MAX_FACTOR_LOG2;
  localparam int LINE_D = IN_W / 2;
  localparam int LIDX_W = (LINE_D > 1) ? $clog2(LINE_D) : 1;
  localparam logic [1:0]              F_MAX  = 2'(MAX_FACTOR_LOG2);
  localparam logic [HCOUNT_WIDTH-1:0] LAST_X = HCOUNT_WIDTH'(IN_W - 1);
  localparam logic [VCOUNT_WIDTH-1:0] LAST_Y = VCOUNT_WIDTH'(IN_H - 1);

  logic                    r_sync;
  logic [1:0]              r_f;
  logic                    r_avg;
  logic [ACC_W-1:0]        r_hacc;
  logic [ACC_W-1:0]        r_line_mem [0:LINE_D-1];
  logic [ACC_W-1:0]        r_line_rdata;

  logic                    r_s1_wr;
  logic                    r_s1_done;
  logic                    r_s1_avg;
  logic [1:0]              r_s1_f;
  logic [ADDR_WIDTH-1:0]   r_s1_addr;
  logic [DATA_WIDTH-1:0]   r_s1_pix;
  logic [ACC_W-1:0]        r_s1_seg;
  logic                    r_s1_row_first;
  logic                    r_s1_line_we;
  logic [LIDX_W-1:0]       r_s1_lidx;

  logic                    w_start;
  logic                    w_sync;
  logic                    w_in_range;
  logic                    w_accept;
  logic                    w_avg;
  logic [1:0]              w_f;
  logic [1:0]              w_f_sat;
  logic [HCOUNT_WIDTH-1:0] w_hmask;
  logic [HCOUNT_WIDTH-1:0] w_xb;
  logic [VCOUNT_WIDTH-1:0] w_vmask;
  logic [VCOUNT_WIDTH-1:0] w_yb;
  logic                    w_seg_first;
  logic                    w_seg_last;
  logic                    w_row_first;
  logic                    w_row_last;
  logic [ADDR_WIDTH-1:0]   w_out_w;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [ACC_W-1:0]        w_seg_sum;
  logic                    w_wr;
  logic                    w_done;
  logic                    w_line_rd;
  logic                    w_line_we;
  logic [LIDX_W-1:0]       w_lidx;
  logic [ACC_W-1:0]        w_line_sum;
  logic [ACC_W-1:0]        w_avg_val;
  logic [MEM_WIDTH-1:0]    w_data;

  // Stage 0: classify the incoming pixel using the config that applies to it
  always_comb begin
    w_f_sat     = (factor_log2_in > F_MAX) ? F_MAX : factor_log2_in;
    w_start     = pixel_valid_in && (pixel_hcount_in == '0) && (pixel_vcount_in == '0);
    // A frame-start pixel already uses the config it latches
    w_f         = w_start ? w_f_sat : r_f;
    w_avg       = w_start ? mode_in : r_avg;
    w_sync      = r_sync || w_start;
    w_in_range  = (32'(pixel_hcount_in) < 32'(IN_W)) && (32'(pixel_vcount_in) < 32'(IN_H));
    w_accept    = pixel_valid_in && w_sync && w_in_range;
    w_hmask     = ~({HCOUNT_WIDTH{1'b1}} << w_f);
    w_vmask     = ~({VCOUNT_WIDTH{1'b1}} << w_f);
    w_xb        = pixel_hcount_in >> w_f;
    w_yb        = pixel_vcount_in >> w_f;
    w_seg_first = (pixel_hcount_in & w_hmask) == '0;
    w_seg_last  = (pixel_hcount_in & w_hmask) == w_hmask;
    w_row_first = (pixel_vcount_in & w_vmask) == '0;
    w_row_last  = (pixel_vcount_in & w_vmask) == w_vmask;
    w_out_w     = ADDR_WIDTH'(IN_W) >> w_f;
    w_addr      = ADDR_WIDTH'(w_xb) + ADDR_WIDTH'(w_yb) * w_out_w;
    w_seg_sum   = (w_seg_first ? {ACC_W{1'b0}} : r_hacc) + ACC_W'(pixel_data_in);
    w_wr        = w_accept && (w_avg ? (w_seg_last && w_row_last)
                                     : (w_seg_first && w_row_first));
    w_done      = w_wr && (w_xb == (LAST_X >> w_f)) && (w_yb == (LAST_Y >> w_f));
    // F=1 never touches the line store: every row is both first and last
    w_line_rd   = w_accept && w_avg && (w_f != 2'd0) && w_seg_first && !w_row_first;
    w_line_we   = w_accept && w_avg && (w_f != 2'd0) && w_seg_last;
    w_lidx      = LIDX_W'(w_xb);
  end

  // Sync flag and per-frame config, captured at each frame start
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_sync <= 1'b0;
      r_f    <= 2'd0;
      r_avg  <= 1'b0;
    end else if (w_start) begin
      r_sync <= 1'b1;
      r_f    <= w_f_sat;
      r_avg  <= mode_in;
    end
  end

  // Horizontal segment accumulator
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_hacc <= '0;
    end else if (w_accept) begin
      r_hacc <= w_seg_sum;
    end
  end

  // Stage 1 pipeline registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_s1_wr        <= 1'b0;
      r_s1_done      <= 1'b0;
      r_s1_avg       <= 1'b0;
      r_s1_f         <= 2'd0;
      r_s1_addr      <= '0;
      r_s1_pix       <= '0;
      r_s1_seg       <= '0;
      r_s1_row_first <= 1'b0;
      r_s1_line_we   <= 1'b0;
      r_s1_lidx      <= '0;
    end else begin
      r_s1_wr        <= w_wr;
      r_s1_done      <= w_done;
      r_s1_avg       <= w_avg;
      r_s1_f         <= w_f;
      r_s1_addr      <= w_addr;
      r_s1_pix       <= pixel_data_in;
      r_s1_seg       <= w_seg_sum;
      r_s1_row_first <= w_row_first;
      r_s1_line_we   <= w_line_we;
      r_s1_lidx      <= w_lidx;
    end
  end

  // Stage 1: fold the segment into the line entry and form the write data
  always_comb begin
    w_line_sum = r_s1_row_first ? r_s1_seg : (r_line_rdata + r_s1_seg);
    w_avg_val  = w_line_sum >> {r_s1_f, 1'b0};
    w_data     = r_s1_avg ? MEM_WIDTH'(w_avg_val[DATA_WIDTH-1:0]) : MEM_WIDTH'(r_s1_pix);
  end

  // Line accumulator store; its content is always rebuilt by a block's first row
  always_ff @(posedge clk_in) begin
    if (r_s1_line_we) begin
      r_line_mem[r_s1_lidx] <= w_line_sum;
    end
    if (w_line_rd) begin
      r_line_rdata <= r_line_mem[w_lidx];
    end
  end

  // Registered frame-buffer write port
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_valid_out   <= 1'b0;
      wr_addr_out    <= '0;
      wr_data_out    <= '0;
      frame_done_out <= 1'b0;
    end else begin
      wr_valid_out   <= r_s1_wr;
      frame_done_out <= r_s1_done;
      if (r_s1_wr) begin
        wr_addr_out <= r_s1_addr;
        wr_data_out <= w_data;
      end
    end
  end

endmodule

// File: tb/tb_luma_downsample_writer.sv
// Bench for luma_downsample_writer: directed cases with literal expectations plus
// random raster frames checked every cycle against a block-level reference model.
module tb_luma_downsample_writer;
  localparam int HW = 10, VW = 9, DW = 8, IW = 32, IH = 16, MAXF = 2, MW = 16, AW = 9;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic [1:0]    factor_log2_in = 2'd0;
  logic          mode_in = 1'b0;
  logic          pixel_valid_in = 1'b0;
  logic [HW-1:0] pixel_hcount_in = '0;
  logic [VW-1:0] pixel_vcount_in = '0;
  logic [DW-1:0] pixel_data_in = '0;
  logic          wr_valid_out;
  logic [AW-1:0] wr_addr_out;
  logic [MW-1:0] wr_data_out;
  logic          frame_done_out;

  luma_downsample_writer #(
    .HCOUNT_WIDTH(HW), .VCOUNT_WIDTH(VW), .DATA_WIDTH(DW), .IN_W(IW), .IN_H(IH),
    .MAX_FACTOR_LOG2(MAXF), .MEM_WIDTH(MW), .ADDR_WIDTH(AW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .factor_log2_in(factor_log2_in), .mode_in(mode_in),
    .pixel_valid_in(pixel_valid_in), .pixel_hcount_in(pixel_hcount_in),
    .pixel_vcount_in(pixel_vcount_in), .pixel_data_in(pixel_data_in),
    .wr_valid_out(wr_valid_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .frame_done_out(frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  int   checks = 0, errors = 0, cyc = 0;
  bit   chk_en = 1'b0;
  logic drv_rst = 1'b0, drv_mode = 1'b0;
  int   drv_factor = 0;

  // expected outputs per driven cycle, visible two cycles later
  logic ev [4];
  logic edn[4];
  int   ea [4];
  int   ed [4];
  int   cmp_i;

  // reference model state: whole-block sums, keyed by output address
  int m_sync = 0, m_f = 0, m_avg = 0;
  int acc [0:IW*IH-1];

  // observed-write capture
  int n_wr, n_done, n_done_bad, n_pat, pat_val, last_addr, last_data, last_wr_cyc;

  task automatic clr_cap();
    n_wr = 0; n_done = 0; n_done_bad = 0; n_pat = 0; last_addr = -1; last_data = -1;
    last_wr_cyc = -1;
  endtask

  task automatic clr_exp();
    for (int i = 0; i < 4; i++) begin
      ev[i] = 1'b0; edn[i] = 1'b0; ea[i] = 0; ed[i] = 0;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_eval(input logic v, input int x, input int y, input int d,
                            output logic wv, output int wa, output int wd, output logic wdn);
    int fsz;
    wv = 1'b0; wa = 0; wd = 0; wdn = 1'b0;
    if (!rst_in) begin
      m_sync = 0; m_f = 0; m_avg = 0;
      return;
    end
    if (!v) return;
    if (x == 0 && y == 0) begin
      m_sync = 1;
      m_f    = (int'(factor_log2_in) > MAXF) ? MAXF : int'(factor_log2_in);
      m_avg  = int'(mode_in);
    end
    if (m_sync == 0 || x >= IW || y >= IH) return;
    fsz = 1 << m_f;
    wa  = (x >> m_f) + (y >> m_f) * (IW >> m_f);
    if (m_avg == 0) begin
      if (x % fsz == 0 && y % fsz == 0) begin
        wv = 1'b1; wd = d;
      end
    end else begin
      if (x % fsz == 0 && y % fsz == 0) acc[wa] = 0;
      acc[wa] += d;
      if (x % fsz == fsz - 1 && y % fsz == fsz - 1) begin
        wv = 1'b1; wd = acc[wa] >> (2 * m_f);
      end
    end
    wdn = wv && ((x >> m_f) == ((IW - 1) >> m_f)) && ((y >> m_f) == ((IH - 1) >> m_f));
  endtask

  task automatic step(input logic v, input int x, input int y, input int d);
    logic wv, wdn;
    int   wa, wd;
    @(posedge clk_in); #1;
    cyc++;
    rst_in          = drv_rst;
    factor_log2_in  = 2'(drv_factor);
    mode_in         = drv_mode;
    pixel_valid_in  = v;
    pixel_hcount_in = HW'(x);
    pixel_vcount_in = VW'(y);
    pixel_data_in   = DW'(d);
    model_eval(v, x, y, d, wv, wa, wd, wdn);
    if (!rst_in) begin
      clr_exp();
    end else begin
      ev[cyc % 4] = wv; ea[cyc % 4] = wa; ed[cyc % 4] = wd; edn[cyc % 4] = wdn;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0);
  endtask

  task automatic px(input int x, input int y, input int d);
    step(1'b1, x, y, d);
    step(1'b0, 0, 0, 0);
  endtask

  // Per-cycle comparison of the DUT write port against the model
  always @(negedge clk_in) begin
    if (chk_en) begin
      cmp_i = (cyc + 2) % 4;
      checks++;
      if (wr_valid_out !== ev[cmp_i] || frame_done_out !== edn[cmp_i] ||
          (ev[cmp_i] && (int'(wr_addr_out) != ea[cmp_i] || int'(wr_data_out) != ed[cmp_i]))) begin
        errors++;
        $display("FAIL cycle_cmp cyc=%0d: got v=%0b a=%0d d=%0d done=%0b expected v=%0b a=%0d d=%0d done=%0b",
                 cyc, wr_valid_out, wr_addr_out, wr_data_out, frame_done_out,
                 ev[cmp_i], ea[cmp_i], ed[cmp_i], edn[cmp_i]);
      end
      if (wr_valid_out) begin
        n_wr++;
        last_addr   = int'(wr_addr_out);
        last_data   = int'(wr_data_out);
        last_wr_cyc = cyc;
        if (int'(wr_data_out) == pat_val) n_pat++;
      end
      if (frame_done_out) begin
        n_done++;
        if (!wr_valid_out) n_done_bad++;
      end
    end
  end

  initial begin
    int k, lim, cnt;
    clr_exp();
    clr_cap();
    pat_val = -1;
    #1;
    idle(3);
    chk("reset_valid", int'(wr_valid_out), 0);
    chk("reset_addr", int'(wr_addr_out), 0);
    chk("reset_data", int'(wr_data_out), 0);
    chk("reset_done", int'(frame_done_out), 0);
    chk_en = 1'b1;
    drv_rst = 1'b1;
    idle(2);

    // f=0 skip: single pixel write
    drv_factor = 0; drv_mode = 1'b0;
    px(0, 0, 'h11); idle(3); clr_cap();
    step(1'b1, 5, 3, 'h7A); k = cyc; idle(4);
    chk("skip_f0_count", n_wr, 1);
    chk("skip_f0_addr", last_addr, 5 + 3 * IW);
    chk("skip_f0_data", last_data, 'h7A);
    chk("skip_f0_latency", last_wr_cyc, k + 2);

    // f=1 skip: one write per 2x2 block, from the top-left pixel
    drv_factor = 1;
    px(0, 0, 'h01); idle(3); clr_cap();
    px(2, 2, 'h33); px(3, 2, 'h44); px(2, 3, 'h55); px(3, 3, 'h66); idle(3);
    chk("skip_f1_count", n_wr, 1);
    chk("skip_f1_addr", last_addr, 17);
    chk("skip_f1_data", last_data, 'h33);

    // f=1 average: (10+20+30+41)>>2 = 25
    drv_mode = 1'b1;
    px(0, 0, 'h00); idle(3); clr_cap();
    px(4, 6, 10); px(5, 6, 20); px(4, 7, 30);
    step(1'b1, 5, 7, 41); k = cyc; idle(4);
    chk("avg_f1_count", n_wr, 1);
    chk("avg_f1_addr", last_addr, 50);
    chk("avg_f1_data", last_data, 25);
    chk("avg_f1_latency", last_wr_cyc, k + 2);

    // factor 3 saturates to 2; full frame of 0xFF
    drv_factor = 3; clr_cap(); pat_val = 'hFF;
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++) px(x, y, 'hFF);
    idle(4);
    chk("full_count", n_wr, (IW / 4) * (IH / 4));
    chk("full_data_ff", n_pat, (IW / 4) * (IH / 4));
    chk("full_last_addr", last_addr, (IW / 4) * (IH / 4) - 1);
    chk("full_done_count", n_done, 1);
    chk("full_done_aligned", n_done_bad, 0);

    // mode switched to skip mid-frame: averaging holds until the next frame start
    drv_factor = 1; drv_mode = 1'b1; clr_cap(); pat_val = 2;
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++) begin
        px(x, y, (x % 2) * 4);
        drv_mode = 1'b0;
      end
    idle(4);
    chk("cfg_hold_avg", n_pat, (IW / 2) * (IH / 2));
    clr_cap(); pat_val = 0;
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++) px(x, y, (x % 2) * 4);
    idle(4);
    chk("cfg_next_skip_count", n_wr, (IW / 2) * (IH / 2));
    chk("cfg_next_skip_data", n_pat, (IW / 2) * (IH / 2));

    // asynchronous reset mid-block
    drv_factor = 1; drv_mode = 1'b0;
    px(0, 0, 'h10);
    step(1'b1, 2, 0, 'h20); step(1'b0, 0, 0, 0); step(1'b1, 3, 0, 'h30);
    #1;
    chk("prerst_valid", int'(wr_valid_out), 1);
    rst_in = 1'b0; drv_rst = 1'b0; clr_exp();
    m_sync = 0; m_f = 0; m_avg = 0;
    #1;
    chk("rst_async_valid", int'(wr_valid_out), 0);
    chk("rst_async_addr", int'(wr_addr_out), 0);
    chk("rst_async_data", int'(wr_data_out), 0);
    chk("rst_async_done", int'(frame_done_out), 0);
    idle(2);
    drv_rst = 1'b1;
    idle(2); clr_cap();
    px(4, 2, 'h21); px(6, 4, 'h22); px(0, 1, 'h23); idle(3);
    chk("rst_nosync_writes", n_wr, 0);
    px(0, 0, 'h09); px(2, 0, 'h08); idle(3);
    chk("rst_resume_count", n_wr, 2);
    chk("rst_resume_addr", last_addr, 1);
    chk("rst_resume_data", last_data, 'h08);

    // random frames, some aborted part-way, random config churn and blanking pixels
    for (int fr = 0; fr < 6; fr++) begin
      drv_factor = $urandom_range(0, 3);
      drv_mode   = 1'($urandom_range(0, 1));
      lim = ($urandom_range(0, 2) == 0) ? $urandom_range(5, IW * IH - 1) : IW * IH;
      cnt = 0;
      for (int y = 0; y < IH && cnt < lim; y++) begin
        for (int x = 0; x < IW && cnt < lim; x++) begin
          step(1'b1, x, y, $urandom_range(0, 255));
          drv_factor = $urandom_range(0, 3);
          drv_mode   = 1'($urandom_range(0, 1));
          idle($urandom_range(1, 2));
          cnt++;
        end
        if ($urandom_range(0, 3) == 0) begin
          px(IW, y, $urandom_range(0, 255));
          px(IW + 1, y, $urandom_range(0, 255));
        end
      end
      idle(3);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
